// File: rtl/spi_slave_regs.sv
// SPI responder with a byte-wide register file.
// Frames are {rw, addr[6:0], data[7:0]}, MSB first, oversampled on clk.
module spi_slave_regs #(
    parameter int unsigned CPOL    = 0,
    parameter int unsigned CPHA    = 1,
    parameter int unsigned N_REGS  = 16,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  n_cs,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  wr_stb,
    output logic [6:0]            wr_addr,
    output logic [7:0]            wr_data,
    output logic [8*N_REGS-1:0]   regs_flat,
    output logic                  frame_err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } state_e;

    localparam logic SCK_IDLE = CPOL[0];

    state_e      state_q;
    logic [2:0]  cs_q;
    logic [2:0]  sck_q;
    logic [1:0]  mosi_q;
    logic [3:0]  cnt_q;
    logic [7:0]  sr_q;
    logic [7:0]  out_sr_q;
    logic [6:0]  addr_q;
    logic        rw_q;
    logic [7:0]  regs_q [N_REGS];
    logic        miso_q;
    logic        wr_stb_q;
    logic        frame_err_q;
    logic        busy_q;
    logic [6:0]  wr_addr_q;
    logic [7:0]  wr_data_q;

    logic        cs_rise;
    logic        cs_fall;
    logic        sck_rise;
    logic        sck_fall;
    logic        smp_edge;
    logic        shf_edge;
    logic [7:0]  byte_d;
    logic [7:0]  rd_data_d;
    logic        addr_ok;

    // n_cs syncs reset low so a chip select held low across reset is not a new frame
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cs_q   <= '0;
            sck_q  <= {3{SCK_IDLE}};
            mosi_q <= '0;
        end else begin
            cs_q   <= {cs_q[1:0], n_cs};
            sck_q  <= {sck_q[1:0], sclk};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    always_comb begin
        cs_rise  = cs_q[1] & ~cs_q[2];
        cs_fall  = ~cs_q[1] & cs_q[2];
        sck_rise = sck_q[1] & ~sck_q[2];
        sck_fall = ~sck_q[1] & sck_q[2];
        smp_edge = (CPOL == CPHA) ? sck_rise : sck_fall;
        shf_edge = (CPOL == CPHA) ? sck_fall : sck_rise;
        byte_d   = {sr_q[6:0], mosi_q[1]};
        addr_ok  = {25'd0, addr_q} < N_REGS;
        rd_data_d = 8'h00;
        for (int i = 0; i < N_REGS; i++) begin
            if (byte_d[6:0] == 7'(i)) begin
                rd_data_d = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            out_sr_q    <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            miso_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else begin
            wr_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
            if (smp_edge) begin
                sr_q <= byte_d;
            end
            unique case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        cnt_q   <= '0;
                        state_q <= CMD;
                        busy_q  <= 1'b1;
                    end
                end
                CMD: begin
                    miso_q <= 1'b0;
                    if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end else if (smp_edge) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rw_q     <= byte_d[7];
                            addr_q   <= byte_d[6:0];
                            out_sr_q <= rd_data_d;
                            state_q  <= DATA;
                        end
                    end
                end
                DATA: begin
                    // abort has priority over a coincident 16th sample
                    if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        miso_q      <= 1'b0;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end else if (shf_edge) begin
                        miso_q   <= out_sr_q[7];
                        out_sr_q <= {out_sr_q[6:0], 1'b0};
                    end else if (smp_edge) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            state_q <= DONE;
                            if (!rw_q && addr_ok) begin
                                wr_stb_q  <= 1'b1;
                                wr_addr_q <= addr_q;
                                wr_data_q <= byte_d;
                                for (int i = 0; i < N_REGS; i++) begin
                                    if (addr_q == 7'(i)) begin
                                        regs_q[i] <= byte_d;
                                    end
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        miso_q  <= 1'b0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_REGS; i++) begin : g_flat
        assign regs_flat[8*i +: 8] = regs_q[i];
    end

    assign miso      = miso_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
